hazard_freeze_controller: RTL and testbench

Pipeline sequencer placed beside the ID-stage instruction decoder in the 5-stage MIPS core. It consumes the decoded control bits (wb_enable, mem_read, mem_write, is_single_source, branch outcome) from the ID/EX/MEM/WB stages and produces the stall, bubble, flush and global-freeze signals. A multi-cycle SRAM access FSM freezes the whole pipeline for a fixed wait. A saturating stall counter gives performance visibility.

---
 rtl/core_pkg.sv | 17 +
 rtl/sram_wait_fsm.sv | 52 +++++
 rtl/hazard_freeze_controller.sv | 129 ++++++++++++
 tb/tb_hazard_freeze_controller.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/core_pkg.sv
// Shared definitions for the MIPS core pipeline control: register width,
// forward-select encodings and SRAM wait FSM state codes.
package core_pkg;

  localparam int REG_AW = 5;

  localparam logic [1:0] FWD_RF  = 2'd0;
  localparam logic [1:0] FWD_MEM = 2'd1;
  localparam logic [1:0] FWD_WB  = 2'd2;

  typedef logic [1:0] sram_state_t;

  localparam sram_state_t SRAM_IDLE = 2'd0;
  localparam sram_state_t SRAM_WAIT = 2'd1;
  localparam sram_state_t SRAM_DONE = 2'd2;

endpackage

// File: rtl/sram_wait_fsm.sv
// Multi-cycle data-SRAM access sequencer: freezes the pipeline for
// SRAM_WAIT_CYCLES cycles starting the same cycle mem_req is seen.
module sram_wait_fsm
  import core_pkg::*;
#(
  parameter int SRAM_WAIT_CYCLES = 5
) (
  input  logic clk,
  input  logic rst,
  input  logic mem_req,
  output logic pipe_freeze,
  output logic sram_done
);

  localparam int CW = (SRAM_WAIT_CYCLES > 2) ? $clog2(SRAM_WAIT_CYCLES) : 1;
  localparam logic [CW-1:0] LOAD_VAL = CW'(SRAM_WAIT_CYCLES - 1);
  localparam logic [CW-1:0] LAST_VAL = CW'(1);

  sram_state_t state;
  logic [CW-1:0] cnt;

  // The IDLE cycle that sees mem_req is the first frozen cycle, so WAIT only
  // covers the remaining SRAM_WAIT_CYCLES-1 cycles.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= SRAM_IDLE;
      cnt   <= '0;
    end else begin
      case (state)
        SRAM_IDLE: begin
          if (mem_req) begin
            state <= SRAM_WAIT;
            cnt   <= LOAD_VAL;
          end
        end
        SRAM_WAIT: begin
          if (cnt == LAST_VAL) begin
            state <= SRAM_DONE;
          end else begin
            cnt <= cnt - LAST_VAL;
          end
        end
        SRAM_DONE: state <= SRAM_IDLE;
        default:   state <= SRAM_IDLE;
      endcase
    end
  end

  assign pipe_freeze = rst && (((state == SRAM_IDLE) && mem_req) || (state == SRAM_WAIT));
  assign sram_done   = rst && (state == SRAM_DONE);

endmodule

// File: rtl/hazard_freeze_controller.sv
// ID-stage pipeline sequencer: stall/bubble/flush/freeze generation and a
// saturating stall counter. Optional operand forwarding via FORWARDING_EN.
module hazard_freeze_controller
  import core_pkg::*;
#(
  parameter int SRAM_WAIT_CYCLES = 5,
  parameter int REG_AW           = core_pkg::REG_AW,
  parameter int CNT_W            = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [REG_AW-1:0] id_src1,
  input  logic [REG_AW-1:0] id_src2,
  input  logic              id_is_single_source,
  input  logic              id_mem_write,
  input  logic [REG_AW-1:0] ex_dest,
  input  logic              ex_wb_en,
  input  logic              ex_mem_read,
  input  logic [REG_AW-1:0] mem_dest,
  input  logic              mem_wb_en,
  input  logic              mem_req,
  input  logic              branch_taken,
  output logic              pc_freeze,
  output logic              if_id_freeze,
  output logic              id_ex_bubble,
  output logic              if_id_flush,
  output logic              pipe_freeze,
  output logic              sram_done,
  output logic [1:0]        fwd_a_sel,
  output logic [1:0]        fwd_b_sel,
  input  logic [REG_AW-1:0] wb_dest,
  input  logic              wb_wb_en,
  output logic [CNT_W-1:0]  stall_count
);

  function automatic logic reg_hit(input logic [REG_AW-1:0] src,
                                   input logic [REG_AW-1:0] dest,
                                   input logic              en);
    reg_hit = en && (src != '0) && (src == dest);
  endfunction

  logic src2_used;
  logic hazard;

  assign src2_used = !id_is_single_source || id_mem_write;

  sram_wait_fsm #(
    .SRAM_WAIT_CYCLES(SRAM_WAIT_CYCLES)
  ) u_sram_fsm (
    .clk        (clk),
    .rst        (rst),
    .mem_req    (mem_req),
    .pipe_freeze(pipe_freeze),
    .sram_done  (sram_done)
  );

`ifdef FORWARDING_EN
  logic [REG_AW-1:0] ex_src1;
  logic [REG_AW-1:0] ex_src2;

  // Only a load in EX cannot be forwarded in time; everything else is bypassed.
  assign hazard = ex_mem_read &&
                  (reg_hit(id_src1, ex_dest, ex_wb_en) ||
                   (src2_used && reg_hit(id_src2, ex_dest, ex_wb_en)));

  always_ff @(posedge clk) begin
    if (!rst) begin
      ex_src1 <= '0;
      ex_src2 <= '0;
    end else if (!pipe_freeze && !id_ex_bubble) begin
      ex_src1 <= id_src1;
      ex_src2 <= id_src2;
    end
  end

  always_comb begin
    fwd_a_sel = FWD_RF;
    fwd_b_sel = FWD_RF;
    if (rst) begin
      if (reg_hit(ex_src1, mem_dest, mem_wb_en))     fwd_a_sel = FWD_MEM;
      else if (reg_hit(ex_src1, wb_dest, wb_wb_en))  fwd_a_sel = FWD_WB;
      if (reg_hit(ex_src2, mem_dest, mem_wb_en))     fwd_b_sel = FWD_MEM;
      else if (reg_hit(ex_src2, wb_dest, wb_wb_en))  fwd_b_sel = FWD_WB;
    end
  end
`else
  logic unused_fwd_inputs;

  assign hazard = reg_hit(id_src1, ex_dest, ex_wb_en) ||
                  reg_hit(id_src1, mem_dest, mem_wb_en) ||
                  (src2_used && (reg_hit(id_src2, ex_dest, ex_wb_en) ||
                                 reg_hit(id_src2, mem_dest, mem_wb_en)));

  assign fwd_a_sel = FWD_RF;
  assign fwd_b_sel = FWD_RF;
  assign unused_fwd_inputs = ^{wb_dest, wb_wb_en, ex_mem_read};
`endif

  // Freeze outranks a taken branch, which outranks a data stall; a frozen EX
  // re-presents its branch once the SRAM access completes.
  always_comb begin
    pc_freeze    = 1'b0;
    if_id_freeze = 1'b0;
    id_ex_bubble = 1'b0;
    if_id_flush  = 1'b0;
    if (rst) begin
      if (pipe_freeze) begin
        pc_freeze    = 1'b1;
        if_id_freeze = 1'b1;
      end else if (branch_taken) begin
        if_id_flush  = 1'b1;
        id_ex_bubble = 1'b1;
      end else if (hazard) begin
        pc_freeze    = 1'b1;
        if_id_freeze = 1'b1;
        id_ex_bubble = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      stall_count <= '0;
    end else if (pc_freeze && (stall_count != '1)) begin
      stall_count <= stall_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_hazard_freeze_controller.sv
// Scoreboard bench for hazard_freeze_controller (SRAM_WAIT_CYCLES=5, CNT_W=6);
// forwarding expectations follow FORWARDING_EN when it is defined.
module tb_hazard_freeze_controller;

`ifdef FORWARDING_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif
  localparam int CNT_W = 6;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef struct {
    logic       rst;
    logic [4:0] src1, src2;
    logic       single, mw;
    logic [4:0] exd;
    logic       exwb, exmr;
    logic [4:0] memd;
    logic       memwb, memreq, br;
    logic [4:0] wbd;
    logic       wbwb;
  } stim_t;

  typedef struct {
    string            name;
    logic [5:0]       flags;
    logic [1:0]       fa, fb;
    logic [CNT_W-1:0] cnt;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  logic [4:0] id_src1, id_src2, ex_dest, mem_dest, wb_dest;
  logic id_is_single_source, id_mem_write, ex_wb_en, ex_mem_read;
  logic mem_wb_en, mem_req, branch_taken, wb_wb_en;
  logic pc_freeze, if_id_freeze, id_ex_bubble, if_id_flush, pipe_freeze, sram_done;
  logic [1:0] fwd_a_sel, fwd_b_sel;
  logic [CNT_W-1:0] stall_count;

  int checks = 0;
  int errors = 0;
  exp_t sb[$];
  logic [CNT_W-1:0] exp_cnt = '0;

  always #5 clk = ~clk;

  hazard_freeze_controller #(
    .SRAM_WAIT_CYCLES(5),
    .REG_AW(5),
    .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst(rst),
    .id_src1(id_src1), .id_src2(id_src2),
    .id_is_single_source(id_is_single_source), .id_mem_write(id_mem_write),
    .ex_dest(ex_dest), .ex_wb_en(ex_wb_en), .ex_mem_read(ex_mem_read),
    .mem_dest(mem_dest), .mem_wb_en(mem_wb_en), .mem_req(mem_req),
    .branch_taken(branch_taken),
    .pc_freeze(pc_freeze), .if_id_freeze(if_id_freeze), .id_ex_bubble(id_ex_bubble),
    .if_id_flush(if_id_flush), .pipe_freeze(pipe_freeze), .sram_done(sram_done),
    .fwd_a_sel(fwd_a_sel), .fwd_b_sel(fwd_b_sel),
    .wb_dest(wb_dest), .wb_wb_en(wb_wb_en),
    .stall_count(stall_count)
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  function automatic stim_t idle();
    stim_t s;
    s.rst = 1'b1; s.src1 = 5'd1; s.src2 = 5'd2; s.single = 1'b0; s.mw = 1'b0;
    s.exd = 5'd0; s.exwb = 1'b0; s.exmr = 1'b0; s.memd = 5'd0; s.memwb = 1'b0;
    s.memreq = 1'b0; s.br = 1'b0; s.wbd = 5'd0; s.wbwb = 1'b0;
    return s;
  endfunction

  task automatic drive(input stim_t s);
    rst = s.rst; id_src1 = s.src1; id_src2 = s.src2;
    id_is_single_source = s.single; id_mem_write = s.mw;
    ex_dest = s.exd; ex_wb_en = s.exwb; ex_mem_read = s.exmr;
    mem_dest = s.memd; mem_wb_en = s.memwb; mem_req = s.memreq;
    branch_taken = s.br; wb_dest = s.wbd; wb_wb_en = s.wbwb;
  endtask

  // flags = {pc_freeze, if_id_freeze, id_ex_bubble, if_id_flush, pipe_freeze, sram_done}
  task automatic applyStimulus(input string name, input stim_t s, input logic [5:0] flags,
                               input logic [1:0] fa, input logic [1:0] fb);
    exp_t e;
    drive(s);
    e.name = name; e.flags = flags; e.fa = fa; e.fb = fb; e.cnt = exp_cnt;
    sb.push_back(e);
    if (!s.rst) exp_cnt = '0;
    else if (flags[5] && exp_cnt != CNT_MAX) exp_cnt = exp_cnt + 1'b1;
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      checkOutput({e.name, ".flags"},
                  {26'd0, pc_freeze, if_id_freeze, id_ex_bubble, if_id_flush, pipe_freeze, sram_done},
                  {26'd0, e.flags});
      checkOutput({e.name, ".fwd_a"}, {30'd0, fwd_a_sel}, {30'd0, e.fa});
      checkOutput({e.name, ".fwd_b"}, {30'd0, fwd_b_sel}, {30'd0, e.fb});
      checkOutput({e.name, ".stall_count"}, {26'd0, stall_count}, {26'd0, e.cnt});
    end
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    stim_t s;
    s = idle(); s.rst = 1'b0;
    drive(s);
    @(posedge clk);
    #1;

    for (int i = 0; i < 3; i++) begin
      s = idle(); s.rst = 1'b0; s.memreq = 1'b1; s.br = 1'b1;
      s.src1 = 5'd3; s.exd = 5'd3; s.exwb = 1'b1;
      applyStimulus($sformatf("reset%0d", i), s, 6'b000000, 2'd0, 2'd0);
    end

    s = idle(); s.src1 = 5'd3; s.exd = 5'd3; s.exwb = 1'b1;
    applyStimulus("raw_ex", s, FWD ? 6'b000000 : 6'b111000, 2'd0, 2'd0);
    s = idle(); s.src1 = 5'd0; s.exd = 5'd0; s.exwb = 1'b1;
    applyStimulus("raw_r0", s, 6'b000000, 2'd0, 2'd0);
    s = idle(); s.single = 1'b1; s.src2 = 5'd4; s.memd = 5'd4; s.memwb = 1'b1;
    applyStimulus("single_src", s, 6'b000000, 2'd0, 2'd0);
    s.mw = 1'b1;
    applyStimulus("store_src2", s, FWD ? 6'b000000 : 6'b111000, 2'd0, 2'd0);
    s = idle(); s.br = 1'b1; s.src1 = 5'd3; s.exd = 5'd3; s.exwb = 1'b1;
    applyStimulus("branch_hazard", s, 6'b001100, 2'd0, 2'd0);

    s = idle(); s.memreq = 1'b1;
    applyStimulus("sram_f0", s, 6'b110010, 2'd0, 2'd0);
    s = idle(); s.br = 1'b1;
    applyStimulus("sram_f1_branch", s, 6'b110010, 2'd0, 2'd0);
    s = idle(); s.src1 = 5'd3; s.exd = 5'd3; s.exwb = 1'b1; s.exmr = 1'b1;
    applyStimulus("sram_f2_hazard", s, 6'b110010, 2'd0, 2'd0);
    s = idle(); s.memreq = 1'b1;
    applyStimulus("sram_f3", s, 6'b110010, 2'd0, 2'd0);
    applyStimulus("sram_f4", s, 6'b110010, 2'd0, 2'd0);
    applyStimulus("sram_done", s, 6'b000001, 2'd0, 2'd0);
    s = idle();
    applyStimulus("sram_after", s, 6'b000000, 2'd0, 2'd0);

    s = idle(); s.memreq = 1'b1;
    applyStimulus("abort_f0", s, 6'b110010, 2'd0, 2'd0);
    s = idle();
    applyStimulus("abort_f1", s, 6'b110010, 2'd0, 2'd0);
    s = idle(); s.rst = 1'b0;
    applyStimulus("abort_rst", s, 6'b000000, 2'd0, 2'd0);
    s = idle();
    applyStimulus("abort_idle0", s, 6'b000000, 2'd0, 2'd0);
    applyStimulus("abort_idle1", s, 6'b000000, 2'd0, 2'd0);
    s = idle(); s.memreq = 1'b1;
    applyStimulus("abort_restart", s, 6'b110010, 2'd0, 2'd0);
    s = idle();
    for (int i = 1; i < 5; i++)
      applyStimulus($sformatf("restart_f%0d", i), s, 6'b110010, 2'd0, 2'd0);
    applyStimulus("restart_done", s, 6'b000001, 2'd0, 2'd0);

    s = idle(); s.src1 = 5'd7;
    applyStimulus("fwd_latch", s, 6'b000000, 2'd0, 2'd0);
    s = idle(); s.memd = 5'd7; s.memwb = 1'b1; s.wbd = 5'd7; s.wbwb = 1'b1;
    applyStimulus("fwd_mem_wins", s, 6'b000000, FWD ? 2'd1 : 2'd0, 2'd0);
    s = idle(); s.wbd = 5'd1; s.wbwb = 1'b1;
    applyStimulus("fwd_wb", s, 6'b000000, FWD ? 2'd2 : 2'd0, 2'd0);
    s = idle(); s.src1 = 5'd7; s.exd = 5'd7; s.exwb = 1'b1; s.exmr = 1'b1;
    applyStimulus("load_use", s, 6'b111000, 2'd0, 2'd0);
    s = idle(); s.src1 = 5'd7; s.memd = 5'd7; s.memwb = 1'b1;
    applyStimulus("load_in_mem", s, FWD ? 6'b000000 : 6'b111000, 2'd0, 2'd0);

    for (int i = 0; i < 70; i++) begin
      s = idle(); s.src1 = 5'd9; s.exd = 5'd9; s.exwb = 1'b1; s.exmr = 1'b1;
      applyStimulus($sformatf("sat%0d", i), s, 6'b111000, 2'd0, 2'd0);
    end
    s = idle();
    applyStimulus("sat_hold", s, 6'b000000, 2'd0, 2'd0);

    @(negedge clk);
    checkOutput("scoreboard_drain", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
